// File: rtl/threshold_pipeline_controller.sv
// Purpose: sequences box_filter then threshold, muxes the threshold-RAM port and gates result writes.
// Latency: status outputs are registered (valid one cycle after the deciding edge); RAM mux is combinational.
// Backpressure: none; stages signal completion via finished inputs, a watchdog bounds each stage.
module threshold_pipeline_controller #(
  parameter int WIDTH_BITS   = 8,
  parameter int HEIGHT_BITS  = 8,
  parameter int TIMEOUT_BITS = 20,
  parameter int CYCLE_BITS   = 24
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   iStart,
  input  logic                   iAbort,
  output logic                   oBusy,
  output logic                   oDone,
  output logic                   oError,
  output logic [CYCLE_BITS-1:0]  oCycles,
  output logic                   oBoxReset,
  input  logic                   iBoxFinished,
  input  logic [WIDTH_BITS-1:0]  iBoxCol,
  input  logic [HEIGHT_BITS-1:0] iBoxRow,
  input  logic [7:0]             iBoxData,
  input  logic                   iBoxWren,
  output logic                   oThrReset,
  input  logic                   iThrFinished,
  input  logic [WIDTH_BITS-1:0]  iThrCol,
  input  logic [HEIGHT_BITS-1:0] iThrRow,
  input  logic                   iThrResultWren,
  output logic [WIDTH_BITS-1:0]  oRamCol,
  output logic [HEIGHT_BITS-1:0] oRamRow,
  output logic [7:0]             oRamData,
  output logic                   oRamWren,
  output logic                   oResultWren
);

  typedef enum logic [2:0] {
    IDLE, BOX_RST, BOX_RUN, THR_RST, THR_RUN, DONE, ERROR
  } state_t;

  // Expiry fires on the cycle the count including the current one reaches 2**TIMEOUT_BITS-1.
  localparam logic [TIMEOUT_BITS-1:0] WD_LAST = {{(TIMEOUT_BITS-1){1'b1}}, 1'b0};

  state_t                  state, state_next;
  logic [TIMEOUT_BITS-1:0] wd_count;
  logic                    wd_expired;
  logic                    start_accept;
  logic                    run_busy;

  // Decode helpers shared by the FSM and the counters.
  always_comb begin
    wd_expired   = (wd_count == WD_LAST);
    start_accept = iStart && ((state == IDLE) || (state == ERROR));
    run_busy     = (state == BOX_RST) || (state == BOX_RUN) ||
                   (state == THR_RST) || (state == THR_RUN);
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; abort outranks everything in busy states, finished outranks expiry.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (iStart) state_next = BOX_RST;
      BOX_RST: state_next = iAbort ? IDLE : BOX_RUN;
      BOX_RUN: begin
        if (iAbort)            state_next = IDLE;
        else if (iBoxFinished) state_next = THR_RST;
        else if (wd_expired)   state_next = ERROR;
      end
      THR_RST: state_next = iAbort ? IDLE : THR_RUN;
      THR_RUN: begin
        if (iAbort)            state_next = IDLE;
        else if (iThrFinished) state_next = DONE;
        else if (wd_expired)   state_next = ERROR;
      end
      DONE:    state_next = IDLE;
      ERROR:   if (iStart) state_next = BOX_RST;
      default: state_next = IDLE;
    endcase
  end

  // Status and stage resets registered from the next state so they track the state glitch-free.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      oBusy     <= 1'b0;
      oDone     <= 1'b0;
      oError    <= 1'b0;
      oBoxReset <= 1'b1;
      oThrReset <= 1'b1;
    end else begin
      oBusy     <= (state_next == BOX_RST) || (state_next == BOX_RUN) ||
                   (state_next == THR_RST) || (state_next == THR_RUN);
      oDone     <= (state_next == DONE);
      oError    <= (state_next == ERROR);
      oBoxReset <= (state_next != BOX_RUN);
      oThrReset <= (state_next != THR_RUN);
    end
  end

  // Watchdog: restarts whenever a run state is entered, counts while staying in it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                    wd_count <= '0;
    else if (state_next != state) wd_count <= '0;
    else if ((state == BOX_RUN) || (state == THR_RUN))
      wd_count <= wd_count + TIMEOUT_BITS'(1);
  end

  // Run-cycle counter: cleared by an accepted start, saturating count of busy cycles.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                          oCycles <= '0;
    else if (start_accept)              oCycles <= '0;
    else if (run_busy && (oCycles != '1)) oCycles <= oCycles + CYCLE_BITS'(1);
  end

  // Threshold-RAM port ownership and result-write gating follow the current state.
  always_comb begin
    oRamCol     = '0;
    oRamRow     = '0;
    oRamData    = '0;
    oRamWren    = 1'b0;
    oResultWren = 1'b0;
    case (state)
      BOX_RUN: begin
        oRamCol  = iBoxCol;
        oRamRow  = iBoxRow;
        oRamData = iBoxData;
        oRamWren = iBoxWren;
      end
      THR_RUN: begin
        oRamCol     = iThrCol;
        oRamRow     = iThrRow;
        oResultWren = iThrResultWren;
      end
      default: ;
    endcase
  end

endmodule
